// File: rtl/knight_anim_sequencer.sv
// knight_anim_sequencer: animation state/frame, facing, attack hitbox window and damage blink for the knight sprite
// Ports:
//   frame_clk      in   clock, all logic on its rising edge
//   Reset          in   synchronous active-high reset
//   Player_Status  in   0 idle, 1 walk, 2 jump up, 3 down, 4 attack, 5-15 idle
//   Inverse        in   facing request, 0 right, 1 left
//   Player_Life    in   remaining lives
//   Anim_State     out  IDLE=0 WALK=1 RISE=2 FALL=3 ATTACK=4 DEAD=5
//   Anim_Frame     out  frame index within the current state
//   Facing_Left    out  registered facing, frozen during an attack
//   Attack_Active  out  hitbox valid
//   Attack_Done    out  one-cycle pulse when an attack finishes
//   Sprite_Visible out  low during the invisible blink phases
//   Dead           out  death latched until Reset
module knight_anim_sequencer #(
  parameter int STEP_DIV      = 6,
  parameter int IDLE_FRAMES   = 4,
  parameter int WALK_FRAMES   = 6,
  parameter int ATTACK_FRAMES = 5,
  parameter int HIT_FIRST     = 1,
  parameter int HIT_LAST      = 3,
  parameter int COOLDOWN      = 8,
  parameter int BLINK_TICKS   = 60,
  parameter int BLINK_PERIOD  = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [3:0] Player_Status,
  input  logic       Inverse,
  input  logic [3:0] Player_Life,
  output logic [2:0] Anim_State,
  output logic [2:0] Anim_Frame,
  output logic       Facing_Left,
  output logic       Attack_Active,
  output logic       Attack_Done,
  output logic       Sprite_Visible,
  output logic       Dead
);
  typedef enum logic [2:0] {IDLE = 3'd0, WALK = 3'd1, RISE = 3'd2, FALL = 3'd3, ATTACK = 3'd4, DEAD = 3'd5} state_t;
  localparam int DW = $clog2(STEP_DIV + 1);
  localparam int CW = $clog2(COOLDOWN + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int PW = $clog2(BLINK_PERIOD + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(STEP_DIV - 1);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);
  localparam logic [BW-1:0] BL_LOAD = BW'(BLINK_TICKS);
  localparam logic [PW-1:0] PH_MAX  = PW'(BLINK_PERIOD - 1);
  localparam logic [2:0] I_LAST  = 3'(IDLE_FRAMES - 1);
  localparam logic [2:0] W_LAST  = 3'(WALK_FRAMES - 1);
  localparam logic [2:0] A_LAST  = 3'(ATTACK_FRAMES - 1);
  localparam logic [2:0] H_FIRST = 3'(HIT_FIRST);
  localparam logic [2:0] H_LAST  = 3'(HIT_LAST);
  state_t state, nxt, mapped;
  logic [DW-1:0] div, div_nxt;
  logic [CW-1:0] cooldown;
  logic [BW-1:0] blink;
  logic [PW-1:0] phase;
  logic [3:0] prev_life;
  logic [2:0] frame_nxt, frame_adv;
  logic step, done;
  assign Anim_State = state;
  always_comb begin
    mapped = Player_Status == 4'd1 ? WALK : Player_Status == 4'd2 ? RISE : Player_Status == 4'd3 ? FALL : IDLE;
    step = div == DIV_MAX;
    done = 1'b0;
    nxt = state;
    // Death wins over everything, and an attack ignores status until its last tick.
    if (Player_Life == 4'd0 || state == DEAD) nxt = DEAD;
    else if (state == ATTACK) begin
      done = step && Anim_Frame == A_LAST;
      nxt = done ? mapped : ATTACK;
    end else if (Player_Status == 4'd4) nxt = cooldown == '0 ? ATTACK : state;
    else nxt = mapped;
    frame_adv = state == IDLE ? (Anim_Frame == I_LAST ? 3'd0 : Anim_Frame + 3'd1) :
                state == WALK ? (Anim_Frame == W_LAST ? 3'd0 : Anim_Frame + 3'd1) :
                state == RISE || state == FALL ? 3'd1 :
                state == ATTACK ? Anim_Frame + 3'd1 : 3'd0;
    frame_nxt = nxt != state ? 3'd0 : step ? frame_adv : Anim_Frame;
    div_nxt = nxt != state || step ? '0 : div + 1'b1;
  end
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= IDLE;
      Anim_Frame <= 3'd0;
      div <= '0;
      Facing_Left <= 1'b0;
      Attack_Active <= 1'b0;
      Attack_Done <= 1'b0;
      Dead <= 1'b0;
      cooldown <= '0;
      prev_life <= 4'd0;
      blink <= '0;
      phase <= '0;
      Sprite_Visible <= 1'b1;
    end else begin
      state <= nxt;
      Anim_Frame <= frame_nxt;
      div <= div_nxt;
      Facing_Left <= state == ATTACK ? Facing_Left : Inverse;
      Attack_Active <= nxt == ATTACK && frame_nxt >= H_FIRST && frame_nxt <= H_LAST;
      Attack_Done <= done;
      Dead <= nxt == DEAD;
      cooldown <= done ? CD_LOAD : cooldown != '0 ? cooldown - 1'b1 : '0;
      prev_life <= Player_Life;
      // Outside DEAD a drop implies Player_Life is nonzero, so a drop always (re)starts the blink.
      if (nxt == DEAD) begin
        blink <= '0;
        phase <= '0;
        Sprite_Visible <= 1'b1;
      end else if (Player_Life < prev_life) begin
        blink <= BL_LOAD;
        phase <= '0;
        Sprite_Visible <= 1'b0;
      end else if (blink != '0) begin
        blink <= blink - 1'b1;
        if (blink == BW'(1)) Sprite_Visible <= 1'b1;
        else if (phase == PH_MAX) begin
          Sprite_Visible <= ~Sprite_Visible;
          phase <= '0;
        end else phase <= phase + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_knight_anim_sequencer.sv
// tb_knight_anim_sequencer: scenario and randomized checks of knight_anim_sequencer against a tick-age reference model
module tb_knight_anim_sequencer;
  localparam int STEP = 6, ATT_LEN = 30, CD = 8, BLINK = 60, HALF = 4;
  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  logic [3:0] Player_Status = 4'd0;
  logic Inverse = 1'b0;
  logic [3:0] Player_Life = 4'd0;
  logic [2:0] Anim_State, Anim_Frame;
  logic Facing_Left, Attack_Active, Attack_Done, Sprite_Visible, Dead;
  int vectors = 0;
  int miscompares = 0;
  int m_state, m_age, m_edge, m_last_done, m_blink, m_prev;
  bit m_face, m_done;
  always #5 frame_clk = ~frame_clk;
  knight_anim_sequencer dut (
    .frame_clk(frame_clk), .Reset(Reset), .Player_Status(Player_Status), .Inverse(Inverse),
    .Player_Life(Player_Life), .Anim_State(Anim_State), .Anim_Frame(Anim_Frame),
    .Facing_Left(Facing_Left), .Attack_Active(Attack_Active), .Attack_Done(Attack_Done),
    .Sprite_Visible(Sprite_Visible), .Dead(Dead)
  );
  function automatic int mapped(int s);
    return s == 1 ? 1 : s == 2 ? 2 : s == 3 ? 3 : 0;
  endfunction
  // Reference: frames derive from the age within a state, cooldown from the edge of the last
  // attack end, and blink visibility from the age since the last damage.
  task automatic model_step();
    int nxt;
    bit dn;
    m_edge++;
    if (Reset) begin
      m_state = 0; m_age = 0; m_last_done = -1000; m_blink = BLINK; m_prev = 0; m_face = 0; m_done = 0;
      return;
    end
    dn = 0;
    if (m_state == 5 || Player_Life == 0) nxt = 5;
    else if (m_state == 4) begin
      dn = m_age == ATT_LEN - 1;
      nxt = dn ? mapped(int'(Player_Status)) : 4;
    end else if (Player_Status == 4) nxt = (m_edge - m_last_done > CD) ? 4 : m_state;
    else nxt = mapped(int'(Player_Status));
    if (dn) m_last_done = m_edge;
    if (m_state != 4) m_face = Inverse;
    m_age = nxt == m_state ? m_age + 1 : 0;
    if (nxt == 5) m_blink = BLINK;
    else if (int'(Player_Life) < m_prev) m_blink = 0;
    else if (m_blink < BLINK) m_blink++;
    m_prev = int'(Player_Life);
    m_state = nxt;
    m_done = dn;
  endtask
  function automatic logic [12:0] exp_vec();
    int f;
    bit aa, vis;
    f = m_state == 0 ? (m_age / STEP) % 4 : m_state == 1 ? (m_age / STEP) % 6 :
        (m_state == 2 || m_state == 3) ? (m_age >= STEP ? 1 : 0) : m_state == 4 ? m_age / STEP : 0;
    aa = m_state == 4 && f >= 1 && f <= 3;
    vis = m_blink >= BLINK ? 1'b1 : ((m_blink / HALF) % 2 == 1);
    return {3'(m_state), 3'(f), m_face, aa, m_done, vis, m_state == 5};
  endfunction
  function automatic logic [12:0] act_vec();
    return {Anim_State, Anim_Frame, Facing_Left, Attack_Active, Attack_Done, Sprite_Visible, Dead};
  endfunction
  task automatic tick(input bit rst, input int st, input bit inv, input int life);
    Reset = rst; Player_Status = 4'(st); Inverse = inv; Player_Life = 4'(life);
    @(posedge frame_clk);
    model_step();
    #1;
  endtask
  task automatic test_reset();
    tick(1, 4, 1, 5);
    tick(1, 4, 1, 5);
    vectors++;
    if (act_vec() !== 13'b000_000_0_0_0_1_0) begin
      miscompares++;
      $display("FAIL reset_values got %h expected %h", act_vec(), 13'b000_000_0_0_0_1_0);
    end
    tick(0, 0, 0, 5);
    vectors++;
    if (act_vec() !== exp_vec() || Sprite_Visible !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_cycle got %h expected %h", act_vec(), exp_vec());
    end
  endtask
  task automatic test_walk();
    for (int i = 0; i < 40; i++) begin
      tick(0, 1, 0, 5);
      vectors++;
      if (act_vec() !== exp_vec() || Anim_State !== 3'd1 || Anim_Frame !== 3'((i / STEP) % 6) || Attack_Active !== 1'b0) begin
        miscompares++;
        $display("FAIL walk i=%0d got %h expected %h frame %0d", i, act_vec(), exp_vec(), (i / STEP) % 6);
      end
    end
  endtask
  task automatic test_attack();
    int in_att = 0, aa = 0, dn = 0;
    bit seen = 0;
    tick(0, 4, 0, 5);
    if (Anim_State == 3'd4) in_att++;
    vectors++;
    if (act_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL attack_start got %h expected %h", act_vec(), exp_vec());
    end
    for (int i = 0; i < 60 && !seen; i++) begin
      tick(0, 0, 0, 5);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL attack_seq i=%0d got %h expected %h", i, act_vec(), exp_vec());
      end
      if (Anim_State == 3'd4) in_att++;
      if (Attack_Active) aa++;
      if (Attack_Done) begin
        dn++;
        seen = 1;
        vectors++;
        if (Anim_State !== 3'd0 || Anim_Frame !== 3'd0) begin
          miscompares++;
          $display("FAIL attack_exit state %0d frame %0d expected 0 0", Anim_State, Anim_Frame);
        end
      end
    end
    vectors++;
    if (in_att != ATT_LEN || aa != 18 || dn != 1) begin
      miscompares++;
      $display("FAIL attack_counts att=%0d hit=%0d done=%0d expected 30 18 1", in_att, aa, dn);
    end
  endtask
  task automatic test_back_to_back();
    int first = -1, second = -1;
    bit was_att = 0;
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 5);
    for (int i = 0; i < 80; i++) begin
      tick(0, 4, i >= 10 && i < 20, 5);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b i=%0d got %h expected %h", i, act_vec(), exp_vec());
      end
      if (Anim_State == 3'd4 && !was_att) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      was_att = Anim_State == 3'd4;
      if (i < ATT_LEN) begin
        vectors++;
        if (Facing_Left !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_facing i=%0d got %b expected 0", i, Facing_Left);
        end
      end
    end
    vectors++;
    if (first != 0 || second != 39) begin
      miscompares++;
      $display("FAIL b2b_starts got %0d,%0d expected 0,39", first, second);
    end
  endtask
  task automatic test_blink();
    int kk;
    bit ev;
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 5);
    for (int k = 0; k < 90; k++) begin
      tick(0, 0, 0, k < 20 ? 4 : 3);
      kk = k < 20 ? k : k - 20;
      ev = kk >= BLINK ? 1'b1 : ((kk / HALF) % 2 == 1);
      vectors++;
      if (act_vec() !== exp_vec() || Sprite_Visible !== ev) begin
        miscompares++;
        $display("FAIL blink k=%0d vis %b expected %b (got %h model %h)", k, Sprite_Visible, ev, act_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_rise_fall();
    int es, ef;
    for (int i = 0; i < 30; i++) begin
      tick(0, i < 12 ? 2 : i < 24 ? 3 : 9, 0, 3);
      es = i < 12 ? 2 : i < 24 ? 3 : 0;
      ef = i < 12 ? (i >= STEP ? 1 : 0) : i < 24 ? (i - 12 >= STEP ? 1 : 0) : 0;
      vectors++;
      if (act_vec() !== exp_vec() || Anim_State !== 3'(es) || Anim_Frame !== 3'(ef)) begin
        miscompares++;
        $display("FAIL rise_fall i=%0d state %0d frame %0d expected %0d %0d", i, Anim_State, Anim_Frame, es, ef);
      end
    end
  endtask
  task automatic test_death();
    tick(0, 0, 0, 5);
    tick(0, 4, 0, 4);
    for (int i = 0; i < 9; i++) tick(0, 0, 0, 4);
    vectors++;
    if (act_vec() !== exp_vec() || Attack_Active !== 1'b1) begin
      miscompares++;
      $display("FAIL death_pre got %h expected %h", act_vec(), exp_vec());
    end
    tick(0, 0, 1, 0);
    vectors++;
    if (act_vec() !== exp_vec() || Anim_State !== 3'd5 || Dead !== 1'b1 || Attack_Active !== 1'b0 ||
        Sprite_Visible !== 1'b1 || Attack_Done !== 1'b0) begin
      miscompares++;
      $display("FAIL death_entry got %h expected %h", act_vec(), exp_vec());
    end
    for (int i = 0; i < 20; i++) begin
      tick(0, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 15)));
      vectors++;
      if (act_vec() !== exp_vec() || Anim_State !== 3'd5 || Dead !== 1'b1) begin
        miscompares++;
        $display("FAIL death_hold i=%0d got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    tick(1, 0, 0, 5);
    vectors++;
    if (act_vec() !== 13'b000_000_0_0_0_1_0) begin
      miscompares++;
      $display("FAIL death_reset got %h expected %h", act_vec(), 13'b000_000_0_0_0_1_0);
    end
  endtask
  task automatic test_random();
    int st = 0, life = 5;
    bit inv = 0, rst;
    tick(1, 0, 0, 5);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) st = $urandom_range(0, 3) == 0 ? 4 : int'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) inv = ~inv;
      if ($urandom_range(0, 39) == 0) life = (life > 1 && $urandom_range(0, 2) != 0) ? life - 1 : int'($urandom_range(1, 15));
      if ($urandom_range(0, 599) == 0) life = 0;
      rst = $urandom_range(0, 399) == 0;
      if (rst) life = 5;
      tick(rst, st, inv, life);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random i=%0d got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask
  initial begin
    m_edge = 0;
    test_reset();
    test_walk();
    test_attack();
    test_back_to_back();
    test_blink();
    test_rise_fall();
    test_death();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog timeout after %0d vectors", vectors);
    $fatal(1, "timeout");
  end
endmodule
